// File: rtl/fpga_rst_seq_if.sv
// Signal bundle between the board reset sequencer and its neighbours:
// PLL lock and ndmreset in, sequenced resets and lock status out.
interface fpga_rst_seq_if;
  logic       pll_locked_i;
  logic       ndmreset_i;
  logic       dm_rst_no;
  logic       soc_rst_no;
  logic [1:0] rst_state_o;
  logic       lock_lost_o;
  logic [7:0] lock_loss_cnt_o;

  modport master (
    output pll_locked_i,
    output ndmreset_i,
    input  dm_rst_no,
    input  soc_rst_no,
    input  rst_state_o,
    input  lock_lost_o,
    input  lock_loss_cnt_o
  );

  modport slave (
    input  pll_locked_i,
    input  ndmreset_i,
    output dm_rst_no,
    output soc_rst_no,
    output rst_state_o,
    output lock_lost_o,
    output lock_loss_cnt_o
  );
endinterface

// File: rtl/fpga_rst_seq.sv
// Board reset sequencer: qualifies PLL lock, releases dm_top then SoC/UART reset,
// folds in ndmreset. Optional lock-loss counter: FPGA_RST_SEQ_LOCK_CNT_EN.
module fpga_rst_seq #(
  parameter int LockStableCycles = 1024,
  parameter int SocRstHoldCycles = 16,
  parameter int NdmRstMinCycles  = 8,
  parameter int SyncStages       = 2
) (
  input  logic          core_clk,
  input  logic          sys_rst_n,
  fpga_rst_seq_if.slave bus
);

  localparam int LockW = (LockStableCycles > 1) ? $clog2(LockStableCycles) : 1;
  localparam int HoldW = (SocRstHoldCycles > 1) ? $clog2(SocRstHoldCycles) : 1;
  localparam int NdmW  = (NdmRstMinCycles  > 1) ? $clog2(NdmRstMinCycles)  : 1;

  localparam logic [LockW-1:0] LockMax = LockW'(LockStableCycles - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(SocRstHoldCycles - 1);
  localparam logic [NdmW-1:0]  NdmMax  = NdmW'(NdmRstMinCycles - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SOC_HOLD  = 2'd1,
    RUN       = 2'd2,
    NDM       = 2'd3
  } state_e;

  logic [1:0]            rst_sync_r;
  logic                  rst_n_s;
  logic [SyncStages-1:0] sync_r;
  logic                  s_lock_s;

  state_e                state_r, state_nxt_s;
  logic [LockW-1:0]      lock_cnt_r, lock_cnt_nxt_s;
  logic [HoldW-1:0]      hold_cnt_r, hold_cnt_nxt_s;
  logic [NdmW-1:0]       ndm_cnt_r, ndm_cnt_nxt_s;
  logic                  dm_rst_r, dm_rst_nxt_s;
  logic                  soc_rst_r, soc_rst_nxt_s;
  logic                  lock_lost_r, lock_lost_nxt_s;

  // Board reset: asserts asynchronously, releases two edges later on core_clk.
  always_ff @(posedge core_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // PLL lock synchroniser; the only consumer of pll_locked_i.
  always_ff @(posedge core_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SyncStages-2:0], bus.pll_locked_i};
    end
  end

  assign s_lock_s = sync_r[SyncStages-1];

  // Sequencer state, counters and registered reset outputs.
  always_ff @(posedge core_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r     <= WAIT_LOCK;
      lock_cnt_r  <= '0;
      hold_cnt_r  <= '0;
      ndm_cnt_r   <= '0;
      dm_rst_r    <= 1'b0;
      soc_rst_r   <= 1'b0;
      lock_lost_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      lock_cnt_r  <= lock_cnt_nxt_s;
      hold_cnt_r  <= hold_cnt_nxt_s;
      ndm_cnt_r   <= ndm_cnt_nxt_s;
      dm_rst_r    <= dm_rst_nxt_s;
      soc_rst_r   <= soc_rst_nxt_s;
      lock_lost_r <= lock_lost_nxt_s;
    end
  end

  // Next-state logic; lock loss is applied last so it overrides every other move.
  always_comb begin
    state_nxt_s     = state_r;
    lock_cnt_nxt_s  = lock_cnt_r;
    hold_cnt_nxt_s  = hold_cnt_r;
    ndm_cnt_nxt_s   = ndm_cnt_r;
    dm_rst_nxt_s    = dm_rst_r;
    soc_rst_nxt_s   = soc_rst_r;
    lock_lost_nxt_s = lock_lost_r;

    case (state_r)
      WAIT_LOCK: begin
        dm_rst_nxt_s  = 1'b0;
        soc_rst_nxt_s = 1'b0;
        if (!s_lock_s) begin
          lock_cnt_nxt_s = '0;
        end else if (lock_cnt_r == LockMax) begin
          state_nxt_s    = SOC_HOLD;
          dm_rst_nxt_s   = 1'b1;
          hold_cnt_nxt_s = '0;
        end else begin
          lock_cnt_nxt_s = lock_cnt_r + 1'b1;
        end
      end
      SOC_HOLD: begin
        dm_rst_nxt_s  = 1'b1;
        soc_rst_nxt_s = 1'b0;
        if (bus.ndmreset_i) begin
          state_nxt_s   = NDM;
          ndm_cnt_nxt_s = '0;
        end else if (hold_cnt_r == HoldMax) begin
          state_nxt_s   = RUN;
          soc_rst_nxt_s = 1'b1;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r + 1'b1;
        end
      end
      RUN: begin
        dm_rst_nxt_s  = 1'b1;
        soc_rst_nxt_s = 1'b1;
        if (bus.ndmreset_i) begin
          state_nxt_s   = NDM;
          soc_rst_nxt_s = 1'b0;
          ndm_cnt_nxt_s = '0;
        end else begin
          state_nxt_s = RUN;
        end
      end
      NDM: begin
        dm_rst_nxt_s  = 1'b1;
        soc_rst_nxt_s = 1'b0;
        if (!bus.ndmreset_i && (ndm_cnt_r == NdmMax)) begin
          state_nxt_s    = SOC_HOLD;
          hold_cnt_nxt_s = '0;
        end else if (ndm_cnt_r != NdmMax) begin
          ndm_cnt_nxt_s = ndm_cnt_r + 1'b1;
        end else begin
          ndm_cnt_nxt_s = ndm_cnt_r;
        end
      end
      default: begin
        state_nxt_s    = WAIT_LOCK;
        dm_rst_nxt_s   = 1'b0;
        soc_rst_nxt_s  = 1'b0;
        lock_cnt_nxt_s = '0;
      end
    endcase

    if ((state_r != WAIT_LOCK) && !s_lock_s) begin
      state_nxt_s     = WAIT_LOCK;
      dm_rst_nxt_s    = 1'b0;
      soc_rst_nxt_s   = 1'b0;
      lock_cnt_nxt_s  = '0;
      lock_lost_nxt_s = 1'b1;
    end else begin
      lock_lost_nxt_s = lock_lost_nxt_s;
    end
  end

`ifdef FPGA_RST_SEQ_LOCK_CNT_EN
  logic [7:0] loss_cnt_r;

  // Saturating lock-loss statistic, stepped on the same condition that forces WAIT_LOCK.
  always_ff @(posedge core_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      loss_cnt_r <= 8'h00;
    end else if ((state_r != WAIT_LOCK) && !s_lock_s && (loss_cnt_r != 8'hFF)) begin
      loss_cnt_r <= loss_cnt_r + 8'h01;
    end else begin
      loss_cnt_r <= loss_cnt_r;
    end
  end

  assign bus.lock_loss_cnt_o = loss_cnt_r;
`else
  assign bus.lock_loss_cnt_o = 8'h00;
`endif

  assign bus.dm_rst_no   = dm_rst_r;
  assign bus.soc_rst_no  = soc_rst_r;
  assign bus.rst_state_o = state_r;
  assign bus.lock_lost_o = lock_lost_r;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// Self-checking bench for fpga_rst_seq: directed scenarios plus randomized lock/ndmreset
// traffic checked every cycle against a rule-level reference model.
module tb_fpga_rst_seq;
  localparam int LSC  = 8;
  localparam int HOLD = 4;
  localparam int NRM  = 3;
  localparam int SS   = 2;
`ifdef FPGA_RST_SEQ_LOCK_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic core_clk = 1'b0;
  logic sys_rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  fpga_rst_seq_if bus ();

  fpga_rst_seq #(
    .LockStableCycles(LSC),
    .SocRstHoldCycles(HOLD),
    .NdmRstMinCycles (NRM),
    .SyncStages      (SS)
  ) dut (
    .core_clk (core_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 core_clk = ~core_clk;

  // Reference model: phase 0 WAIT, 1 HOLD, 2 RUN, 3 NDM; timers count edges spent in a phase.
  int m_phase, m_run, m_elapsed, m_lost, m_losses, m_ignore;
  bit m_hist[$];

  function automatic void model_reset();
    m_hist = {};
    for (int i = 0; i < SS; i++) m_hist.push_back(1'b0);
    m_phase = 0; m_run = 0; m_elapsed = 0; m_lost = 0; m_losses = 0; m_ignore = 0;
  endfunction

  function automatic void model_step(input bit pll, input bit ndm);
    bit s;
    if (m_ignore > 0) begin
      m_ignore--;
      return;
    end
    s = m_hist.pop_front();
    m_hist.push_back(pll);
    if (m_phase != 0 && !s) begin
      m_phase = 0; m_run = 0; m_lost = 1;
      if (m_losses < 255) m_losses++;
      return;
    end
    case (m_phase)
      0: if (!s) m_run = 0;
         else begin
           m_run++;
           if (m_run == LSC) begin m_phase = 1; m_elapsed = 0; end
         end
      1: if (ndm) begin m_phase = 3; m_elapsed = 0; end
         else begin
           m_elapsed++;
           if (m_elapsed == HOLD) m_phase = 2;
         end
      2: if (ndm) begin m_phase = 3; m_elapsed = 0; end
      3: begin
           m_elapsed++;
           if (!ndm && m_elapsed >= NRM) begin m_phase = 1; m_elapsed = 0; end
         end
      default: m_phase = 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("dm_rst_no", bus.dm_rst_no, m_phase != 0);
    chk("soc_rst_no", bus.soc_rst_no, m_phase == 2);
    chk("rst_state_o", bus.rst_state_o, m_phase);
    chk("lock_lost_o", bus.lock_lost_o, m_lost);
    chk("lock_loss_cnt_o", bus.lock_loss_cnt_o, CntEn ? m_losses : 0);
  endtask

  // One clock: inputs applied between edges, model stepped at the edge, outputs checked on negedge.
  task automatic cycle(input bit p, input bit n);
    bus.pll_locked_i = p;
    bus.ndmreset_i   = n;
    @(posedge core_clk);
    model_step(p, n);
    @(negedge core_clk);
    check_all();
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    bus.pll_locked_i = 1'b0;
    bus.ndmreset_i   = 1'b0;
    model_reset();
    repeat (3) @(negedge core_clk);
    sys_rst_n = 1'b1;
    m_ignore = 2;
    repeat (4) cycle(1'b0, 1'b0);
  endtask

  initial begin
    int dm_edge, soc_edge, low, lo_left, ndm_left;
    bit done, dm_dropped;
    logic [1:0] seq[$];

    do_reset();
    chk("reset_dm", bus.dm_rst_no, 0);
    chk("reset_state", bus.rst_state_o, 0);

    // 1: clean lock -> dm at edge 10, soc at edge 14
    dm_edge = 0; soc_edge = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, 1'b0);
      if (bus.dm_rst_no && dm_edge == 0) dm_edge = i;
      if (bus.soc_rst_no && soc_edge == 0) soc_edge = i;
    end
    chk("t1_dm_edge", dm_edge, 10);
    chk("t1_soc_edge", soc_edge, 14);
    chk("t1_state_run", bus.rst_state_o, 2);

    // 2: one-cycle glitch after 5 high cycles restarts qualification
    do_reset();
    dm_edge = 0;
    for (int i = 1; i <= 25; i++) begin
      cycle(i != 6, 1'b0);
      if (bus.dm_rst_no && dm_edge == 0) dm_edge = i;
    end
    chk("t2_dm_edge", dm_edge, 16);
    chk("t2_lock_lost", bus.lock_lost_o, 0);

    // 3: single-cycle ndmreset pulse in RUN
    chk("t3_in_run", bus.rst_state_o, 2);
    cycle(1'b1, 1'b1);
    chk("t3_latency", bus.soc_rst_no, 0);
    low = 1; done = 0; dm_dropped = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0);
      if (!bus.dm_rst_no) dm_dropped = 1;
      if (!bus.soc_rst_no && !done) low++;
      else done = 1;
    end
    chk("t3_soc_low_len", low, NRM + HOLD);
    chk("t3_dm_stays", dm_dropped, 0);

    // 4: ndmreset held 10 cycles; state path 2->3->1->2
    seq = {};
    seq.push_back(bus.rst_state_o);
    low = 0; done = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle(1'b1, i <= 10);
      if (bus.rst_state_o != seq[seq.size()-1]) seq.push_back(bus.rst_state_o);
      if (!bus.soc_rst_no && !done) low++;
      else if (low > 0) done = 1;
      else done = 0;
    end
    chk("t4_soc_low_len", low, 10 + HOLD);
    chk("t4_seq_len", seq.size(), 4);
    if (seq.size() == 4) begin
      chk("t4_seq1", seq[1], 3);
      chk("t4_seq2", seq[2], 1);
      chk("t4_seq3", seq[3], 2);
    end

    // 5: lock loss in RUN, then repeated to saturation
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    chk("t5_dm_before", bus.dm_rst_no, 1);
    cycle(1'b0, 1'b0);
    chk("t5_dm_after", bus.dm_rst_no, 0);
    chk("t5_soc_after", bus.soc_rst_no, 0);
    chk("t5_lost", bus.lock_lost_o, 1);
    chk("t5_cnt1", bus.lock_loss_cnt_o, CntEn ? 1 : 0);
    for (int k = 0; k < 299; k++) begin
      for (int j = 0; j < 30 && !bus.dm_rst_no; j++) cycle(1'b1, 1'b0);
      repeat (3) cycle(1'b0, 1'b0);
    end
    chk("t5_cnt_sat", bus.lock_loss_cnt_o, CntEn ? 255 : 0);
    chk("t5_lost_sticky", bus.lock_lost_o, 1);

    // 6: asynchronous reset in SOC_HOLD
    for (int j = 0; j < 30 && bus.rst_state_o != 2'd1; j++) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    chk("t6_in_hold", bus.rst_state_o, 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("t6_dm", bus.dm_rst_no, 0);
    chk("t6_soc", bus.soc_rst_no, 0);
    chk("t6_state", bus.rst_state_o, 0);
    chk("t6_lost", bus.lock_lost_o, 0);
    chk("t6_cnt", bus.lock_loss_cnt_o, 0);
    model_reset();
    bus.pll_locked_i = 1'b0;
    repeat (2) @(negedge core_clk);
    sys_rst_n = 1'b1;
    m_ignore = 2;
    repeat (4) cycle(1'b0, 1'b0);

    // Randomized lock drops and ndmreset bursts against the model
    lo_left = 0; ndm_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (lo_left == 0 && $urandom_range(0, 149) == 0) lo_left = $urandom_range(1, 4);
      if (ndm_left == 0 && $urandom_range(0, 39) == 0) ndm_left = $urandom_range(1, 12);
      cycle(lo_left == 0, ndm_left != 0);
      if (lo_left > 0) lo_left--;
      if (ndm_left > 0) ndm_left--;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fpga_rst_seq.md
Name: fpga_rst_seq

Overview:
Board-level reset sequencer for the FPGA top. It replaces the ad-hoc two-flop lock/reset chain.
- Synchronises PLL lock and qualifies it as stable.
- Releases the debug-module reset (dm_rst_no) first, then the SoC/UART reset (soc_rst_no) after a hold-off.
- Folds in ndmreset from dm_top with a minimum pulse width.
- Reports lock-loss status for the LED logic.
- Sits between the clock/PLL stage and dm_top/ara_soc/uart; drives their rst_ni inputs.

Parameters:
LockStableCycles, 1024, consecutive synchronised-lock cycles required before releasing dm_rst_no; legal range ≥1.
SocRstHoldCycles, 16, cycles soc_rst_no stays low after dm_rst_no release and after each ndmreset exit; legal range ≥1.
NdmRstMinCycles, 8, minimum cycles soc_rst_no stays low per ndmreset episode; legal range ≥1.
SyncStages, 2, flop stages on pll_locked_i; legal range ≥2.

Ports:
core_clk  input  1  core clock (50 MHz, PLL CLKOUT0 via BUFG).
sys_rst_n  input  1  board reset, asynchronous, active-low.
pll_locked_i  input  1  PLL LOCKED, asynchronous to core_clk.
ndmreset_i  input  1  dm_top ndmreset_o, synchronous to core_clk.
dm_rst_no  output  1  reset for dm_top, active-low.
soc_rst_no  output  1  reset for ara_soc and uart, active-low.
rst_state_o  output  2  FSM state: 0 WAIT_LOCK, 1 SOC_HOLD, 2 RUN, 3 NDM.
lock_lost_o  output  1  sticky flag: lock dropped after first qualification.
lock_loss_cnt_o  output  8  saturating count of lock-loss events.

Behaviour:
- Reset is sys_rst_n, asynchronous, active-low; clock is core_clk. All flops use async assert and synchronous deassert.
- All outputs are flop-driven; there are no combinational paths from inputs to outputs.
- Values while sys_rst_n=0:
  - dm_rst_no=0, soc_rst_no=0.
  - rst_state_o=0 (WAIT_LOCK).
  - lock_lost_o=0, lock_loss_cnt_o=0.
  - Sync chain and all counters cleared.
- Lock synchronisation: s_lock = pll_locked_i delayed by SyncStages flops. No other logic samples pll_locked_i.
- WAIT_LOCK:
  - Both resets are held low.
  - lock_cnt increments on s_lock=1 and clears on s_lock=0.
  - On the edge where s_lock=1 and lock_cnt==LockStableCycles-1: go to SOC_HOLD, dm_rst_no<=1, hold_cnt<=0.
  - ndmreset_i is ignored.
- SOC_HOLD:
  - dm_rst_no=1, soc_rst_no=0.
  - hold_cnt increments each cycle.
  - On hold_cnt==SocRstHoldCycles-1: go to RUN, soc_rst_no<=1.
  - If ndmreset_i=1: go to NDM instead (ndm_cnt<=0). This takes priority over the RUN transition.
- RUN:
  - Both resets are high.
  - If ndmreset_i=1 at an edge: go to NDM and soc_rst_no<=0 at that edge (1-cycle latency). ndm_cnt<=0.
- NDM:
  - soc_rst_no=0, dm_rst_no=1.
  - ndm_cnt increments, saturating at NdmRstMinCycles-1.
  - When ndmreset_i=0 and ndm_cnt==NdmRstMinCycles-1: go to SOC_HOLD with hold_cnt<=0.
  - Net effect: soc_rst_no stays low for ≥NdmRstMinCycles+SocRstHoldCycles cycles per episode.
- Lock loss:
  - Trigger: s_lock=0 in SOC_HOLD, RUN or NDM.
  - Response at the next edge:
    - Go to WAIT_LOCK.
    - dm_rst_no<=0 and soc_rst_no<=0.
    - lock_cnt<=0.
    - lock_lost_o<=1.
    - lock_loss_cnt_o increments, saturating at 255.
  - Lock loss has priority over every other transition, including a simultaneous ndmreset_i.
- lock_lost_o clears only on sys_rst_n.
- Counter widths are $clog2 of the relevant parameter, with a minimum of 1 bit. No wrap-around is possible; all counters compare-and-stop.
- sys_rst_n asserted in any state: immediate asynchronous return to the reset values, including the statistics.

Optional Feature:
Macro: FPGA_RST_SEQ_LOCK_CNT_EN.
- Defined: lock_loss_cnt_o is implemented as described above.
- Undefined: the counter flops are not built and lock_loss_cnt_o is tied to 8'h00. lock_lost_o and all other behaviour are unchanged.

Test Plan:
All scenarios use LockStableCycles=8, SocRstHoldCycles=4, NdmRstMinCycles=3, SyncStages=2.
1. Release sys_rst_n, then raise pll_locked_i synchronously at edge 0 -> dm_rst_no rises at edge 10; soc_rst_no rises at edge 14; rst_state_o goes 0→1→2.
2. pll_locked_i glitches low for 1 cycle after 5 high cycles -> lock_cnt restarts; dm_rst_no rises 8 cycles after the second rise reaches s_lock; lock_lost_o stays 0.
3. In RUN, pulse ndmreset_i for 1 cycle -> soc_rst_no low 1 cycle after the pulse, for exactly 3+4=7 cycles; dm_rst_no stays 1.
4. In RUN, hold ndmreset_i for 10 cycles -> soc_rst_no low for 10+4 cycles from the first NDM edge (±1 per the FSM definition); state sequence 2→3→1→2.
5. Drop pll_locked_i in RUN -> both resets low 3 edges later (2 sync + 1 FSM); lock_lost_o=1; lock_loss_cnt_o=1. Repeat 300 times -> cnt saturates at 255; with the macro undefined it reads 0.
6. Assert sys_rst_n mid-SOC_HOLD -> all outputs return to reset values asynchronously (within the same cycle); lock_lost_o and the count clear.
